alu_seq_ctrl: RTL and testbench

- Sequential command front-end and initiator for the team's 8-bit combinational ALU.
- Accepts operation commands over a valid/ready handshake, drives the ALU's A/B/sel inputs from registers, and captures R and the C/Z/V/N flags one cycle later.
- Returns each result over a second valid/ready handshake.
- Keeps an accumulator for chained operations, sticky carry/overflow status, and an operation counter.
- Sits between a command source (sequencer/CPU datapath) and the ALU instance.

---
 rtl/alu_seq_ctrl_if.sv | 28 ++
 rtl/alu_seq_ctrl.sv | 105 ++++++++++
 tb/tb_alu_seq_ctrl.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_ctrl_if.sv
// Command and result handshakes between a command source and alu_seq_ctrl.
// The controller takes the slave side; the command source takes the master side.
interface alu_seq_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int OPW   = 3
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [OPW-1:0]   cmd_sel;
  logic [WIDTH-1:0] cmd_A;
  logic [WIDTH-1:0] cmd_B;
  logic             cmd_acc;

  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_R;
  logic [3:0]       res_flags;

  modport master (
    output cmd_valid, cmd_sel, cmd_A, cmd_B, cmd_acc, res_ready,
    input  cmd_ready, res_valid, res_R, res_flags
  );

  modport slave (
    input  cmd_valid, cmd_sel, cmd_A, cmd_B, cmd_acc, res_ready,
    output cmd_ready, res_valid, res_R, res_flags
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Sequential front-end for the 8-bit combinational ALU: registers operands,
// captures result/flags one cycle later, keeps accumulator, sticky status and op count.
module alu_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int OPW   = 3,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst,
  alu_seq_ctrl_if.slave    bus,
  output logic [WIDTH-1:0] alu_A,
  output logic [WIDTH-1:0] alu_B,
  output logic [OPW-1:0]   alu_sel,
  input  logic [WIDTH-1:0] alu_R,
  input  logic             alu_C,
  input  logic             alu_Z,
  input  logic             alu_V,
  input  logic             alu_N,
  output logic [WIDTH-1:0] acc,
  output logic             stat_C,
  output logic             stat_V,
  input  logic             stat_clr,
  output logic [CNTW-1:0]  op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

  state_t     state_reg, state_next;
  logic       accept;
  logic       capture;
  logic [1:0] sticky_reg;
  logic [1:0] sticky_next;
  logic [1:0] sticky_in;

  always_comb begin
    state_next    = state_reg;
    bus.cmd_ready = 1'b0;
    bus.res_valid = 1'b0;
    capture       = 1'b0;
    case (state_reg)
      IDLE: begin
        bus.cmd_ready = ~rst;
        if (bus.cmd_valid) state_next = EXEC;
      end
      EXEC: begin
        capture    = 1'b1;
        state_next = HOLD;
      end
      HOLD: begin
        bus.res_valid = 1'b1;
        // Consumer taking the result frees the slot for a same-cycle command.
        bus.cmd_ready = bus.res_ready;
        if (bus.res_ready) state_next = bus.cmd_valid ? EXEC : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept = bus.cmd_valid & bus.cmd_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      alu_A         <= '0;
      alu_B         <= '0;
      alu_sel       <= '0;
      bus.res_R     <= '0;
      bus.res_flags <= '0;
      acc           <= '0;
      op_count      <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        alu_A   <= bus.cmd_acc ? acc : bus.cmd_A;
        alu_B   <= bus.cmd_B;
        alu_sel <= bus.cmd_sel;
      end
      if (capture) begin
        bus.res_R     <= alu_R;
        bus.res_flags <= {alu_C, alu_Z, alu_V, alu_N};
        acc           <= alu_R;
        op_count      <= op_count + CNTW'(1);
      end
    end
  end

  // Sticky bit 0 = carry, bit 1 = overflow; a capture coinciding with a clear keeps the new flag.
  assign sticky_in = {alu_V, alu_C};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sticky
      assign sticky_next[gi] = capture  ? (stat_clr ? sticky_in[gi] : (sticky_reg[gi] | sticky_in[gi])) :
                               stat_clr ? 1'b0 : sticky_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sticky_reg <= '0;
    else     sticky_reg <= sticky_next;
  end

  assign stat_C = sticky_reg[0];
  assign stat_V = sticky_reg[1];

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl with a behavioural ALU closing the loop.
// Expected results are hand-computed constants queued at issue and checked at result transfer.
module tb_alu_seq_ctrl;

  logic        clk;
  logic        rst;
  logic [7:0]  alu_A, alu_B, alu_R, acc;
  logic [2:0]  alu_sel;
  logic        alu_C, alu_Z, alu_V, alu_N;
  logic        stat_C, stat_V, stat_clr;
  logic [15:0] op_count;

  alu_seq_ctrl_if bus ();

  alu_seq_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .alu_A    (alu_A),
    .alu_B    (alu_B),
    .alu_sel  (alu_sel),
    .alu_R    (alu_R),
    .alu_C    (alu_C),
    .alu_Z    (alu_Z),
    .alu_V    (alu_V),
    .alu_N    (alu_N),
    .acc      (acc),
    .stat_C   (stat_C),
    .stat_V   (stat_V),
    .stat_clr (stat_clr),
    .op_count (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the team ALU
  always_comb begin
    alu_R = '0;
    alu_C = 1'b0;
    alu_V = 1'b0;
    case (alu_sel)
      3'd0: begin
        {alu_C, alu_R} = {1'b0, alu_A} + {1'b0, alu_B};
        alu_V = (alu_A[7] == alu_B[7]) && (alu_R[7] != alu_A[7]);
      end
      3'd1: begin
        alu_R = alu_A - alu_B;
        alu_C = alu_A < alu_B;
        alu_V = (alu_A[7] != alu_B[7]) && (alu_R[7] != alu_A[7]);
      end
      3'd2: alu_R = alu_A & alu_B;
      3'd3: alu_R = alu_A | alu_B;
      3'd4: alu_R = alu_A ^ alu_B;
      3'd5: alu_R = ~alu_A;
      3'd6: begin alu_R = {alu_A[6:0], 1'b0}; alu_C = alu_A[7]; end
      default: begin alu_R = {1'b0, alu_A[7:1]}; alu_C = alu_A[0]; end
    endcase
    alu_Z = (alu_R == 8'h00);
    alu_N = alu_R[7];
  end

  typedef struct packed {
    logic [7:0]  r;
    logic [3:0]  f;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          passes = 0;
  logic [15:0] exp_cnt = 16'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic expect_res(input logic [7:0] r, input logic [3:0] f);
    exp_cnt = exp_cnt + 16'd1;
    sb.push_back({r, f, exp_cnt});
  endtask

  // Called just after a rising edge; returns 1 ns after the accepting edge.
  task automatic send(input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b,
                      input logic use_acc, input logic [7:0] r, input logic [3:0] f, input bit push);
    int n = 0;
    if (push) expect_res(r, f);
    bus.cmd_sel   = sel;
    bus.cmd_A     = a;
    bus.cmd_B     = b;
    bus.cmd_acc   = use_acc;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    while (!bus.cmd_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (!bus.cmd_ready) begin
      checks++;
      $display("FAIL accept_timeout: cmd_ready 0, required 1 within 20 cycles");
    end
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    $display("cmd sel=%0d A=0x%02h B=0x%02h acc=%0b", sel, a, b, use_acc);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 30) begin
      n++;
      @(negedge clk);
    end
    chk("drain_queue_empty", sb.size(), 0);
  endtask

  // Monitor: compare on every result transfer
  always @(negedge clk) begin
    if (!rst && bus.res_valid && bus.res_ready) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_result: res_R=0x%02h with no expected entry", bus.res_R);
      end else begin
        mon_e = sb.pop_front();
        $display("res R=0x%02h flags=%04b acc=0x%02h op_count=%0d", bus.res_R, bus.res_flags, acc, op_count);
        chk("res_R", bus.res_R, mon_e.r);
        chk("res_flags", bus.res_flags, mon_e.f);
        chk("acc", acc, mon_e.r);
        chk("op_count", op_count, mon_e.cnt);
      end
    end
  end

  initial begin
    rst           = 1'b1;
    stat_clr      = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_sel   = '0;
    bus.cmd_A     = '0;
    bus.cmd_B     = '0;
    bus.cmd_acc   = 1'b0;
    bus.res_ready = 1'b1;
    #2;
    chk("rst_cmd_ready", bus.cmd_ready, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_alu_A", alu_A, 0);
    chk("rst_acc", acc, 0);
    chk("rst_op_count", op_count, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_cmd_ready", bus.cmd_ready, 1);
    @(posedge clk);
    #1;

    // Add overflow, with latency check
    send(3'd0, 8'h7F, 8'h01, 1'b0, 8'h80, 4'b0011, 1'b1);
    @(negedge clk);
    chk("lat_exec_res_valid", bus.res_valid, 0);
    @(negedge clk);
    chk("lat_hold_res_valid", bus.res_valid, 1);
    chk("add_stat_V", stat_V, 1);
    chk("add_stat_C", stat_C, 0);
    drain();
    @(posedge clk);
    #1;

    // Sub borrow
    send(3'd1, 8'h00, 8'h01, 1'b0, 8'hFF, 4'b1001, 1'b1);
    drain();
    chk("sub_stat_C", stat_C, 1);
    @(posedge clk);
    #1;

    // Accumulator chain, back-to-back
    send(3'd0, 8'h10, 8'h20, 1'b0, 8'h30, 4'b0000, 1'b1);
    send(3'd6, 8'hAA, 8'h00, 1'b1, 8'h60, 4'b0000, 1'b1);
    chk("chain_alu_A", alu_A, 8'h30);
    send(3'd4, 8'hFF, 8'hFF, 1'b0, 8'h00, 4'b0100, 1'b1);
    send(3'd5, 8'h0F, 8'h00, 1'b0, 8'hF0, 4'b0001, 1'b1);
    send(3'd2, 8'hF0, 8'h3C, 1'b0, 8'h30, 4'b0000, 1'b1);
    send(3'd3, 8'h00, 8'h00, 1'b0, 8'h00, 4'b0100, 1'b1);
    send(3'd7, 8'h01, 8'h00, 1'b0, 8'h00, 4'b1100, 1'b1);
    drain();
    @(posedge clk);
    #1;

    // Backpressure with a pending command
    bus.res_ready = 1'b0;
    send(3'd0, 8'h01, 8'h01, 1'b0, 8'h02, 4'b0000, 1'b1);
    expect_res(8'h7F, 4'b0010);
    bus.cmd_sel   = 3'd1;
    bus.cmd_A     = 8'h80;
    bus.cmd_B     = 8'h01;
    bus.cmd_acc   = 1'b0;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("bp_cmd_ready", bus.cmd_ready, 0);
      chk("bp_res_valid", bus.res_valid, 1);
      chk("bp_res_R", bus.res_R, 8'h02);
      chk("bp_res_flags", bus.res_flags, 4'b0000);
      @(negedge clk);
    end
    @(posedge clk);
    #1 bus.res_ready = 1'b1;
    @(negedge clk);
    chk("bp_passthru_ready", bus.cmd_ready, 1);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("bp_exec_res_valid", bus.res_valid, 0);
    @(negedge clk);
    chk("bp_next_res_valid", bus.res_valid, 1);
    drain();
    @(posedge clk);
    #1;

    // stat_clr colliding with a capture: new V=1 survives, C drops to captured 0
    send(3'd0, 8'h7F, 8'h01, 1'b0, 8'h80, 4'b0011, 1'b1);
    stat_clr = 1'b1;
    @(posedge clk);
    #1 stat_clr = 1'b0;
    chk("clr_hit_stat_V", stat_V, 1);
    chk("clr_hit_stat_C", stat_C, 0);
    drain();
    @(posedge clk);
    #1;
    send(3'd0, 8'h01, 8'h01, 1'b0, 8'h02, 4'b0000, 1'b1);
    stat_clr = 1'b1;
    @(posedge clk);
    #1 stat_clr = 1'b0;
    chk("clr_miss_stat_V", stat_V, 0);
    drain();
    @(posedge clk);
    #1;

    // Reset during EXEC discards the operation
    send(3'd0, 8'h03, 8'h04, 1'b0, 8'h07, 4'b0000, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_res_valid", bus.res_valid, 0);
    chk("midrst_cmd_ready", bus.cmd_ready, 0);
    chk("midrst_alu_A", alu_A, 0);
    chk("midrst_alu_B", alu_B, 0);
    chk("midrst_acc", acc, 0);
    chk("midrst_op_count", op_count, 0);
    chk("midrst_stat", {stat_C, stat_V}, 0);
    sb.delete();
    exp_cnt = 16'd0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("postrst_cmd_ready", bus.cmd_ready, 1);
    @(posedge clk);
    #1;
    send(3'd0, 8'h05, 8'h06, 1'b0, 8'h0B, 4'b0000, 1'b1);
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
